hazard_controller: RTL

- Issue/stall/flush controller for the decode stage.
- Tracks in-flight destination registers in a scoreboard and holds decode while a source or destination register is still pending writeback.
- On a jump/branch redirect, steers the PC mux to the computed PC and squashes the wrong-path fetch slots.
- Provides a drain handshake so the pipeline can be quiesced.
- Sits between decode (operand/opcode fields) and the fetch PC register, fed back by the writeback stage.

---
 rtl/hazard_pkg.sv | 24 ++
 rtl/reg_scoreboard.sv | 69 ++++++
 rtl/hazard_controller.sv | 136 +++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the decode-stage hazard controller.
// Decode uses the opcode constants here to form dec_redirect.
package hazard_pkg;

  localparam int REGISTER_SIZE = 5;
  localparam int NUM_REGS      = 32;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Jumps always redirect; a branch redirects only when its condition holds.
  function automatic logic is_redirect(input logic [6:0] opcode, input logic branch_taken);
    return (opcode == OPC_JAL) || (opcode == OPC_JALR) ||
           ((opcode == OPC_BRANCH) && branch_taken);
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-writeback scoreboard: one busy bit per register plus a count of
// outstanding writes. x0 never becomes busy.
module reg_scoreboard #(
  parameter int REGISTER_SIZE = hazard_pkg::REGISTER_SIZE,
  parameter int NUM_REGS      = hazard_pkg::NUM_REGS,
  parameter int CNT_SIZE      = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [REGISTER_SIZE-1:0] rs1_addr,
  input  logic [REGISTER_SIZE-1:0] rs2_addr,
  input  logic [REGISTER_SIZE-1:0] rd_addr,
  output logic                     rs1_busy,
  output logic                     rs2_busy,
  output logic                     rd_busy,
  input  logic                     set_en,
  input  logic [REGISTER_SIZE-1:0] set_addr,
  input  logic                     clr_en,
  input  logic [REGISTER_SIZE-1:0] clr_addr,
  output logic [NUM_REGS-1:0]      busy_mask,
  output logic [CNT_SIZE-1:0]      count
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [CNT_SIZE-1:0] count_q;
  logic [CNT_SIZE-1:0] count_d;
  logic                set_hit;
  logic                clr_hit;

  assign rs1_busy = (rs1_addr != '0) && busy_q[rs1_addr];
  assign rs2_busy = (rs2_addr != '0) && busy_q[rs2_addr];
  assign rd_busy  = (rd_addr  != '0) && busy_q[rd_addr];

  // A writeback to a register that is not pending is ignored entirely, which
  // keeps the in-flight count from underflowing.
  assign set_hit = set_en && (set_addr != '0);
  assign clr_hit = clr_en && (clr_addr != '0) && busy_q[clr_addr];

  always_comb begin
    busy_d  = busy_q;
    count_d = count_q;
    if (clr_hit)
      busy_d[clr_addr] = 1'b0;
    // Set is applied after clear so a new writer of the same register wins.
    if (set_hit)
      busy_d[set_addr] = 1'b1;
    busy_d[0] = 1'b0;
    case ({set_hit, clr_hit})
      2'b10:   count_d = count_q + CNT_SIZE'(1);
      2'b01:   count_d = count_q - CNT_SIZE'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign busy_mask = busy_q;
  assign count     = count_q;

endmodule

// File: rtl/hazard_controller.sv
// Decode-stage issue/stall/flush controller: scoreboard-based interlock,
// redirect squashing of wrong-path fetch slots and a drain handshake.
module hazard_controller #(
  parameter int REGISTER_SIZE = hazard_pkg::REGISTER_SIZE,
  parameter int NUM_REGS      = hazard_pkg::NUM_REGS,
  parameter int FLUSH_CYCLES  = 2,
  parameter int CNT_SIZE      = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     dec_valid,
  input  logic                     dec_rs1_used,
  input  logic [REGISTER_SIZE-1:0] dec_rs1_addr,
  input  logic                     dec_rs2_used,
  input  logic [REGISTER_SIZE-1:0] dec_rs2_addr,
  input  logic                     dec_rd_write,
  input  logic [REGISTER_SIZE-1:0] dec_rd_addr,
  input  logic                     dec_redirect,
  input  logic                     wb_enable,
  input  logic [REGISTER_SIZE-1:0] wb_addr,
  input  logic                     drain_req,
  output logic                     issue,
  output logic                     stall,
  output logic                     flush,
  output logic                     pc_sel,
  output logic                     drain_ack,
  output logic [NUM_REGS-1:0]      busy_mask
);

  import hazard_pkg::*;

  localparam bit MULTI_FLUSH = (FLUSH_CYCLES > 1);
  localparam int FC_W        = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_t              state_q;
  state_t              state_d;
  logic [FC_W-1:0]     flush_cnt_q;
  logic [FC_W-1:0]     flush_cnt_d;
  logic                rs1_busy;
  logic                rs2_busy;
  logic                rd_busy;
  logic                hazard;
  logic                redirect;
  logic [CNT_SIZE-1:0] inflight;
  logic                count_zero;

  reg_scoreboard #(
    .REGISTER_SIZE (REGISTER_SIZE),
    .NUM_REGS      (NUM_REGS),
    .CNT_SIZE      (CNT_SIZE)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .rs1_addr  (dec_rs1_addr),
    .rs2_addr  (dec_rs2_addr),
    .rd_addr   (dec_rd_addr),
    .rs1_busy  (rs1_busy),
    .rs2_busy  (rs2_busy),
    .rd_busy   (rd_busy),
    .set_en    (issue & dec_rd_write),
    .set_addr  (dec_rd_addr),
    .clr_en    (wb_enable),
    .clr_addr  (wb_addr),
    .busy_mask (busy_mask),
    .count     (inflight)
  );

  // No writeback bypass: a register freed this cycle still blocks until the edge.
  assign hazard = (dec_rs1_used & rs1_busy) |
                  (dec_rs2_used & rs2_busy) |
                  (dec_rd_write & rd_busy);

  assign count_zero = (inflight == '0);

  always_comb begin
    issue       = 1'b0;
    stall       = 1'b0;
    flush       = 1'b0;
    pc_sel      = 1'b0;
    drain_ack   = 1'b0;
    redirect    = 1'b0;
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;

    case (state_q)
      RUN: begin
        issue     = dec_valid & ~hazard & ~drain_req;
        stall     = dec_valid & ~issue;
        redirect  = issue & dec_redirect;
        flush     = redirect;
        pc_sel    = redirect;
        drain_ack = count_zero & ~dec_valid;
        // issue already excludes drain_req, so a drain request always wins here.
        if (redirect && MULTI_FLUSH) begin
          state_d     = FLUSH;
          flush_cnt_d = FC_W'(FLUSH_CYCLES - 1);
        end else if (drain_req) begin
          state_d = DRAIN;
        end
      end

      FLUSH: begin
        flush = 1'b1;
        if (flush_cnt_q <= FC_W'(1)) begin
          state_d     = RUN;
          flush_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q - FC_W'(1);
        end
      end

      DRAIN: begin
        stall     = 1'b1;
        drain_ack = count_zero;
        if (!drain_req)
          state_d = RUN;
      end

      default: begin
        state_d     = RUN;
        flush_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule
